// File: rtl/set_time_cursor_ctrl.sv
// set_time_cursor_ctrl: edit buffer, cursor and blink sequencer feeding the set-time window selector
module set_time_cursor_ctrl #(
    parameter int                 N_CHARS   = 21,
    parameter logic [3:0]         EDIT_MODE = 4'd1,
    parameter logic [N_CHARS-1:0] EDIT_MASK = 21'h1FFFFF,
    parameter logic [3:0]         DIGIT_MAX = 4'd9,
    parameter int                 BLINK_DIV = 25_000_000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [3:0]             mode,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_enter,
    input  logic                   btn_cancel,
    input  logic [4*N_CHARS-1:0]   time_in,
    output logic [4*N_CHARS-1:0]   tmp1,
    output logic [4:0]             count,
    output logic                   editing,
    output logic                   blink,
    output logic                   commit
);
    localparam int CTR_W = $clog2(BLINK_DIV + 1);

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

    function automatic logic [4:0] top_idx();
        top_idx = 5'(N_CHARS - 1);
        for (int i = 0; i < N_CHARS; i++)
            if (EDIT_MASK[i]) top_idx = 5'(i);
    endfunction

    localparam logic [4:0] TOP_IDX = top_idx();

    state_t                 state, state_n;
    logic [4*N_CHARS-1:0]   tmp1_n;
    logic [4:0]             count_n, left_idx, right_idx, move_idx;
    logic [CTR_W-1:0]       ctr, ctr_n;
    logic                   blink_n, wrap, moving;
    logic [3:0]             cur, up_d, dn_d;

    always_comb begin
        left_idx  = count;
        right_idx = count;
        for (int i = N_CHARS - 1; i >= 0; i--)
            if (EDIT_MASK[i] && i > int'(count)) left_idx = 5'(i);
        for (int i = 0; i < N_CHARS; i++)
            if (EDIT_MASK[i] && i < int'(count)) right_idx = 5'(i);
        moving   = btn_left || btn_right;
        move_idx = (btn_left && !btn_right) ? left_idx : (btn_right && !btn_left) ? right_idx : count;
        cur      = tmp1[{count, 2'b00} +: 4];
        up_d     = (cur >= DIGIT_MAX) ? 4'd0 : cur + 4'd1;
        dn_d     = (cur == 4'd0 || cur > DIGIT_MAX) ? DIGIT_MAX : cur - 4'd1;
        wrap     = ctr == CTR_W'(BLINK_DIV - 1);
    end

    always_comb begin
        state_n = state;
        tmp1_n  = tmp1;
        count_n = count;
        blink_n = blink;
        ctr_n   = ctr;
        case (state)
            IDLE: if (mode == EDIT_MODE && btn_enter) begin
                state_n = EDIT;
                tmp1_n  = time_in;
                count_n = TOP_IDX;
                blink_n = 1'b1;
                ctr_n   = '0;
            end
            EDIT: begin
                if (mode != EDIT_MODE || btn_cancel) begin
                    state_n = IDLE;
                    blink_n = 1'b0;
                    ctr_n   = '0;
                end else if (btn_enter) begin
                    state_n = COMMIT;
                    blink_n = 1'b0;
                    ctr_n   = '0;
                end else if (moving && move_idx != count) begin
                    count_n = move_idx;
                    blink_n = 1'b1;
                    ctr_n   = '0;
                end else if (!moving && (btn_up ^ btn_down) && EDIT_MASK[count]) begin
                    tmp1_n[{count, 2'b00} +: 4] = btn_up ? up_d : dn_d;
                    blink_n = 1'b1;
                    ctr_n   = '0;
                end else begin
                    // free-running blink when nothing was accepted this cycle
                    ctr_n   = wrap ? '0 : ctr + 1'b1;
                    blink_n = blink ^ wrap;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            tmp1    <= '0;
            count   <= 5'(N_CHARS - 1);
            ctr     <= '0;
            blink   <= 1'b0;
            editing <= 1'b0;
            commit  <= 1'b0;
        end else begin
            state   <= state_n;
            tmp1    <= tmp1_n;
            count   <= count_n;
            ctr     <= ctr_n;
            blink   <= blink_n;
            editing <= state_n == EDIT;
            commit  <= state_n == COMMIT;
        end
    end
endmodule
